// File: rtl/vga_capture_pkg.sv
// Shared constants for the TinyVGA PMOD receive path: byte bit map, capture state
// encoding and default 640x480@60 timing.
package vga_capture_pkg;

  localparam int unsigned PMOD_HSYNC = 7;
  localparam int unsigned PMOD_B0    = 6;
  localparam int unsigned PMOD_G0    = 5;
  localparam int unsigned PMOD_R0    = 4;
  localparam int unsigned PMOD_VSYNC = 3;
  localparam int unsigned PMOD_B1    = 2;
  localparam int unsigned PMOD_G1    = 1;
  localparam int unsigned PMOD_R1    = 0;

  localparam int unsigned DEF_H_TOTAL  = 800;
  localparam int unsigned DEF_H_START  = 144;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_TOTAL  = 525;
  localparam int unsigned DEF_V_START  = 35;
  localparam int unsigned DEF_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    SEARCH,
    SYNCING,
    LOCKED
  } cap_state_t;

  // Reassemble {R[1:0],G[1:0],B[1:0]} from the interleaved PMOD byte.
  function automatic logic [5:0] pmod_rgb(input logic [7:0] b);
    return {b[PMOD_R1], b[PMOD_R0], b[PMOD_G1], b[PMOD_G0], b[PMOD_B1], b[PMOD_B0]};
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// One sync line: input register plus detection of the transition into the
// asserted level (asserted now, previous sample not asserted).
module vga_sync_edge #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic assert_edge
);

  logic s1;
  logic prev;

  // Reset to the idle level so a line already idle after reset yields no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= ~POL;
      prev <= ~POL;
    end else begin
      s1   <= sync_in;
      prev <= s1;
    end
  end

  assign assert_edge = (s1 == POL) && (prev != POL);

endmodule

// File: rtl/vga_pmod_capture.sv
// TinyVGA PMOD receiver: locks to hsync/vsync, rebuilds pixel coordinates and colour,
// checks line and frame length, and reports a per-frame colour checksum.
module vga_pmod_capture
  import vga_capture_pkg::*;
#(
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned H_START  = DEF_H_START,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
  parameter int unsigned V_START  = DEF_V_START,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_pmod,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        err_line,
  output logic        err_frame
);

  localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
  localparam logic [10:0] H_LO      = 11'(H_START);
  localparam logic [10:0] H_HI      = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [9:0]  V_LO      = 10'(V_START);
  localparam logic [9:0]  V_HI      = 10'(V_START + V_ACTIVE);

  logic        hs_edge;
  logic        vs_edge;
  logic [5:0]  rgb_s1;
  logic [5:0]  rgb_d;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  lines;
  logic [9:0]  lines_inc;
  logic [11:0] h_len;
  logic        h_seen;
  logic        line_bad;
  logic        frame_bad;
  logic        leave_locked;
  logic        active;
  logic [15:0] acc;
  cap_state_t  state;

  vga_sync_edge #(.POL(SYNC_POL)) u_hs_edge (
    .clk         (clk),
    .rst         (rst),
    .sync_in     (vga_pmod[PMOD_HSYNC]),
    .assert_edge (hs_edge)
  );

  vga_sync_edge #(.POL(SYNC_POL)) u_vs_edge (
    .clk         (clk),
    .rst         (rst),
    .sync_in     (vga_pmod[PMOD_VSYNC]),
    .assert_edge (vs_edge)
  );

  // lines_inc includes an hs edge coincident with the closing vs edge, so both
  // mid-line and line-aligned vsync placements tally V_TOTAL lines per frame.
  always_comb begin
    h_len        = {1'b0, h_cnt} + 12'd1;
    line_bad     = hs_edge && h_seen && (h_len != H_TOTAL_W);
    lines_inc    = (hs_edge && (lines != '1)) ? lines + 10'd1 : lines;
    frame_bad    = vs_edge && (state != SEARCH) && (lines_inc != V_TOTAL_W);
    leave_locked = (state == LOCKED) && (line_bad || frame_bad);
    active       = (state == LOCKED) &&
                   (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                   (v_cnt >= V_LO) && (v_cnt < V_HI);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SEARCH;
      locked <= 1'b0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (vs_edge) state <= SYNCING;
        end
        SYNCING: begin
          if (line_bad || frame_bad) begin
            state <= SEARCH;
          end else if (vs_edge) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (line_bad || frame_bad) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Timing counters and error pulses, one cycle behind the sync edge detectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_s1    <= '0;
      rgb_d     <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      lines     <= '0;
      h_seen    <= 1'b0;
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      rgb_s1    <= pmod_rgb(vga_pmod);
      rgb_d     <= rgb_s1;
      err_line  <= line_bad;
      err_frame <= frame_bad;
      if (hs_edge) begin
        h_cnt  <= '0;
        h_seen <= 1'b1;
      end else if (h_cnt != '1) begin
        h_cnt <= h_cnt + 11'd1;
      end
      if (vs_edge) begin
        v_cnt <= '0;
        lines <= '0;
      end else begin
        lines <= lines_inc;
        if (hs_edge && (v_cnt != '1)) v_cnt <= v_cnt + 10'd1;
      end
    end
  end

  // Pixel outputs, accumulator and checksum, driven from the aligned h/v counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      acc        <= '0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
    end else begin
      pix_valid  <= active;
      frame_done <= vs_edge && (state == LOCKED) && !frame_bad;
      if (active) begin
        pix_x   <= 10'(h_cnt - H_LO);
        pix_y   <= v_cnt - V_LO;
        pix_rgb <= rgb_d;
      end
      if (vs_edge && (state == LOCKED) && !frame_bad) frame_sum <= acc;
      if (vs_edge || leave_locked) begin
        acc <= '0;
      end else if (active) begin
        acc <= acc + 16'(rgb_d);
      end
    end
  end

endmodule

// File: tb/tb_vga_pmod_capture.sv
// Frame-table bench for vga_pmod_capture on shrunk timing, driving an active-low
// and an active-high sync instance with equivalent streams.
module tb_vga_pmod_capture;

  localparam int HT = 20;
  localparam int HS = 6;
  localparam int HA = 8;
  localparam int VT = 12;
  localparam int VS = 3;
  localparam int VA = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pmod [2];
  logic        pv   [2];
  logic [9:0]  px   [2];
  logic [9:0]  py   [2];
  logic [5:0]  prgb [2];
  logic        lk   [2];
  logic        fd   [2];
  logic [15:0] fs   [2];
  logic        el   [2];
  logic        ef   [2];

  int n_checks = 0;
  int n_fail   = 0;
  int c_valid [2];
  int c_done  [2];
  int c_errl  [2];
  int c_errf  [2];
  int e_idx   [2];

  typedef struct {
    int vs_off;
    int nlines;
    int short_line;
    int valid;
    int done;
    int errl;
    int errf;
    int locked;
    int sum;
  } frame_t;

  frame_t tbl [15];

  always #5 clk = ~clk;

  vga_pmod_capture #(
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .vga_pmod(pmod[0]),
    .pix_valid(pv[0]), .pix_x(px[0]), .pix_y(py[0]), .pix_rgb(prgb[0]),
    .locked(lk[0]), .frame_done(fd[0]), .frame_sum(fs[0]),
    .err_line(el[0]), .err_frame(ef[0])
  );

  vga_pmod_capture #(
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA), .SYNC_POL(1'b1)
  ) dut_pol1 (
    .clk(clk), .rst(rst), .vga_pmod(pmod[1]),
    .pix_valid(pv[1]), .pix_x(px[1]), .pix_y(py[1]), .pix_rgb(prgb[1]),
    .locked(lk[1]), .frame_done(fd[1]), .frame_sum(fs[1]),
    .err_line(el[1]), .err_frame(ef[1])
  );

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (pol%0d): got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input logic hs, input logic vs, input logic [5:0] v);
    return {hs, v[0], v[2], v[4], vs, v[1], v[3], v[5]};
  endfunction

  function automatic logic [46:0] all_outs(input int d);
    return {pv[d], px[d], py[d], prgb[d], lk[d], fd[d], fs[d], el[d], ef[d]};
  endfunction

  // Expected pixels arrive row-major with rgb = x + 8*y.
  task automatic sample();
    logic [25:0] exp_pix;
    for (int d = 0; d < 2; d++) begin
      if (pv[d]) begin
        exp_pix = {10'(e_idx[d] % HA), 10'(e_idx[d] / HA), 6'(e_idx[d])};
        check("pixel", d, {38'd0, px[d], py[d], prgb[d]}, {38'd0, exp_pix});
        e_idx[d]++;
        c_valid[d]++;
      end
      if (fd[d]) c_done[d]++;
      if (el[d]) c_errl[d]++;
      if (ef[d]) c_errf[d]++;
    end
  endtask

  task automatic drive(input logic hsa, input logic vsa, input logic [5:0] v);
    @(negedge clk);
    sample();
    pmod[0] = enc(~hsa, ~vsa, v);
    pmod[1] = enc(hsa, vsa, v);
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      c_valid[d] = 0;
      c_done[d]  = 0;
      c_errl[d]  = 0;
      c_errf[d]  = 0;
      e_idx[d]   = 0;
    end
  endtask

  // stop_at >= 0 ends the frame after that many bytes.
  task automatic run_frame(input int vs_off, input int nlines, input int short_line,
                           input int stop_at);
    int n;
    int len;
    logic hsa;
    logic vsa;
    logic [5:0] v;
    n = 0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        if (stop_at >= 0 && n == stop_at) return;
        hsa = (p < 2);
        vsa = (l == 0 && p >= vs_off) || (l == 1) || (l == 2 && p < vs_off);
        if (l >= VS && l < VS + VA && p >= HS && p < HS + HA)
          v = 6'((p - HS) + 8 * (l - VS));
        else
          v = 6'h2A;
        drive(hsa, vsa, v);
        n++;
      end
    end
  endtask

  task automatic reset_sequence();
    clear_counts();
    run_frame(5, VT, -1, 4 * HT + 9);
    #2 rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("mid_reset_outputs", d, {17'd0, all_outs(d)}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{5, 12, -1,  0, 0, 0, 0, 0,   0};
    tbl[1]  = '{5, 12, -1, 32, 0, 0, 0, 1,   0};
    tbl[2]  = '{5, 12, -1, 32, 1, 0, 0, 1, 496};
    tbl[3]  = '{5, 12,  8, 32, 1, 1, 0, 0, 496};
    tbl[4]  = '{5, 12, -1,  0, 0, 0, 0, 0, 496};
    tbl[5]  = '{5, 12, -1, 32, 0, 0, 0, 1, 496};
    tbl[6]  = '{5, 11, -1, 32, 1, 0, 0, 1, 496};
    tbl[7]  = '{5, 12, -1,  0, 0, 0, 1, 0, 496};
    tbl[8]  = '{5, 12, -1,  0, 0, 0, 0, 0, 496};
    tbl[9]  = '{0, 12, -1, 32, 0, 0, 0, 1, 496};
    tbl[10] = '{0, 12, -1, 32, 1, 0, 0, 1, 496};
    tbl[11] = '{0, 12, -1, 32, 1, 0, 0, 1, 496};
    tbl[12] = '{5, 12, -1,  0, 0, 0, 0, 0,   0};
    tbl[13] = '{5, 12, -1, 32, 0, 0, 0, 1,   0};
    tbl[14] = '{5, 12, -1, 32, 1, 0, 0, 1, 496};

    pmod[0] = enc(1'b1, 1'b1, 6'd0);
    pmod[1] = enc(1'b0, 1'b0, 6'd0);
    clear_counts();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) check("reset_outputs", d, {17'd0, all_outs(d)}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (i == 12) reset_sequence();
      clear_counts();
      run_frame(tbl[i].vs_off, tbl[i].nlines, tbl[i].short_line, -1);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("f%0d_valid_count", i), d, 64'(c_valid[d]), 64'(tbl[i].valid));
        check($sformatf("f%0d_frame_done_count", i), d, 64'(c_done[d]), 64'(tbl[i].done));
        check($sformatf("f%0d_err_line_count", i), d, 64'(c_errl[d]), 64'(tbl[i].errl));
        check($sformatf("f%0d_err_frame_count", i), d, 64'(c_errf[d]), 64'(tbl[i].errf));
        check($sformatf("f%0d_locked", i), d, 64'(lk[d]), 64'(tbl[i].locked));
        check($sformatf("f%0d_frame_sum", i), d, 64'(fs[d]), 64'(tbl[i].sum));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
